ocd_stream_loader: RTL and testbench

OCD_STREAM_LOADER -- requirements
Module: ocd_stream_loader

---
 rtl/RV2T_loader_pkg.sv | 22 ++
 rtl/ocd_stream_loader_if.sv | 25 ++
 rtl/ocd_word_packer.sv | 50 +++++
 rtl/ocd_stream_loader.sv | 162 ++++++++++++++++
 tb/tb_ocd_stream_loader.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/RV2T_loader_pkg.sv
// Shared definitions for the OCD stream loader: command codes, FSM states
// and header field sizes.
package RV2T_loader_pkg;

    localparam logic [7:0] CMD_LOAD  = 8'h01;
    localparam logic [7:0] CMD_START = 8'h02;

    // Header fields are little-endian byte counts following the command byte
    localparam int ADDR_BYTES = 4;
    localparam int LEN_BYTES  = 4;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_WRITE,
        ST_RUN,
        ST_ERR
    } loader_state_t;

endpackage

// File: rtl/ocd_stream_loader_if.sv
// Byte stream input and OCD memory write port of the stream loader.
interface ocd_stream_loader_if #(
    parameter int XLEN          = 32,
    parameter int MEM_ADDR_BITS = 16
) ();

    logic                     s_valid;
    logic [7:0]               s_data;
    logic                     s_ready;
    logic                     ocd_write_enable;
    logic [MEM_ADDR_BITS-1:0] ocd_rw_addr;
    logic [XLEN-1:0]          ocd_write_word;

    // master: byte source and memory sink; slave: the loader
    modport master (
        output s_valid, s_data,
        input  s_ready, ocd_write_enable, ocd_rw_addr, ocd_write_word
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, ocd_write_enable, ocd_rw_addr, ocd_write_word
    );

endinterface

// File: rtl/ocd_word_packer.sv
// Packs payload bytes into an XLEN word in the selected byte order; unfilled
// lanes stay zero because the accumulator is cleared after every word.
module ocd_word_packer
    import RV2T_loader_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            push,
    input  logic [7:0]      byte_in,
    output logic [XLEN-1:0] word_next,
    output logic            last_lane
);

    localparam int NB = XLEN / 8;
    localparam int LW = $clog2(NB);

    logic [XLEN-1:0] acc;
    logic [LW-1:0]   lane;
    logic [LW-1:0]   pos;

    assign pos       = BIG_ENDIAN ? LW'(NB - 1) - lane : lane;
    assign last_lane = (lane == LW'(NB - 1));

    // word_next already contains the byte on the bus, so the loader can
    // latch a completed word in the same cycle its last byte is accepted.
    always_comb begin
        // NOTE: full default before the lane overwrite keeps this purely combinational.
        word_next = acc;
        word_next[pos*8 +: 8] = byte_in;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc  <= '0;
            lane <= '0;
        end else if (clear) begin
            acc  <= '0;
            lane <= '0;
        end else if (push) begin
            acc  <= word_next;
            lane <= lane + LW'(1);
        end
    end

endmodule

// File: rtl/ocd_stream_loader.sv
// Parses LOAD/START records from a byte stream, writes payload words into
// on-chip memory and releases the CPU at the requested entry point.
module ocd_stream_loader
    import RV2T_loader_pkg::*;
#(
    parameter int XLEN               = 32,
    parameter int MEM_ADDR_BITS      = 16,
    parameter int PC_BITWIDTH        = 32,
    parameter int PAYLOAD_BIG_ENDIAN = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    ocd_stream_loader_if.slave     bus,
    output logic                   start,
    output logic [PC_BITWIDTH-1:0] start_address,
    output logic                   busy,
    output logic                   error,
    output logic [31:0]            words_written
);

    localparam int         NB        = XLEN / 8;
    localparam int         ALIGN     = $clog2(NB);
    localparam logic [1:0] ADDR_LAST = 2'(ADDR_BYTES - 1);
    localparam logic [1:0] LEN_LAST  = 2'(LEN_BYTES - 1);

    loader_state_t            state;
    logic [1:0]               hdr_cnt;
    logic [7:0]               cmd;
    logic [31:0]              hdr_sh;
    logic [31:0]              remaining;
    logic                     last_word;
    logic                     s_ready;
    logic                     ocd_write_enable;
    logic [MEM_ADDR_BITS-1:0] ocd_rw_addr;
    logic [XLEN-1:0]          ocd_write_word;

    logic            accept;
    logic [31:0]     hdr_full;
    logic [XLEN-1:0] word_next;
    logic            last_lane;
    logic            complete;

    assign accept   = bus.s_valid & s_ready;
    assign hdr_full = {bus.s_data, hdr_sh[31:8]};
    assign complete = last_lane | (remaining == 32'd1);

    assign bus.s_ready          = s_ready;
    assign bus.ocd_write_enable = ocd_write_enable;
    assign bus.ocd_rw_addr      = ocd_rw_addr;
    assign bus.ocd_write_word   = ocd_write_word;

    ocd_word_packer #(
        .XLEN       (XLEN),
        .BIG_ENDIAN (PAYLOAD_BIG_ENDIAN != 0)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     ((state != ST_DATA) | (accept & complete)),
        .push      ((state == ST_DATA) & accept & ~complete),
        .byte_in   (bus.s_data),
        .word_next (word_next),
        .last_lane (last_lane)
    );

    // Outputs are registered alongside each state change rather than decoded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_CMD;
            hdr_cnt          <= '0;
            cmd              <= '0;
            hdr_sh           <= '0;
            remaining        <= '0;
            last_word        <= 1'b0;
            s_ready          <= 1'b1;
            ocd_write_enable <= 1'b0;
            ocd_rw_addr      <= '0;
            ocd_write_word   <= '0;
            start            <= 1'b0;
            start_address    <= '0;
            busy             <= 1'b0;
            error            <= 1'b0;
            words_written    <= '0;
        end else begin
            case (state)
                ST_CMD: if (accept) begin
                    // Command legality is judged once the address is in.
                    cmd     <= bus.s_data;
                    hdr_cnt <= '0;
                    busy    <= 1'b1;
                    state   <= ST_ADDR;
                end
                ST_ADDR: if (accept) begin
                    hdr_sh  <= hdr_full;
                    hdr_cnt <= hdr_cnt + 2'd1;
                    if (hdr_cnt == ADDR_LAST) begin
                        hdr_cnt <= '0;
                        if (cmd == CMD_LOAD && hdr_full[ALIGN-1:0] == '0) begin
                            ocd_rw_addr <= MEM_ADDR_BITS'(hdr_full >> ALIGN);
                            state       <= ST_LEN;
                        end else if (cmd == CMD_START) begin
                            start_address <= PC_BITWIDTH'(hdr_full);
                            start         <= 1'b1;
                            s_ready       <= 1'b0;
                            busy          <= 1'b0;
                            state         <= ST_RUN;
                        end else begin
                            s_ready <= 1'b0;
                            busy    <= 1'b0;
                            error   <= 1'b1;
                            state   <= ST_ERR;
                        end
                    end
                end
                ST_LEN: if (accept) begin
                    hdr_sh  <= hdr_full;
                    hdr_cnt <= hdr_cnt + 2'd1;
                    if (hdr_cnt == LEN_LAST) begin
                        hdr_cnt <= '0;
                        if (hdr_full == 32'd0) begin
                            busy  <= 1'b0;
                            state <= ST_CMD;
                        end else begin
                            remaining <= hdr_full;
                            state     <= ST_DATA;
                        end
                    end
                end
                ST_DATA: if (accept) begin
                    remaining <= remaining - 32'd1;
                    if (complete) begin
                        ocd_write_word   <= word_next;
                        ocd_write_enable <= 1'b1;
                        s_ready          <= 1'b0;
                        last_word        <= (remaining == 32'd1);
                        state            <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    ocd_write_enable <= 1'b0;
                    s_ready          <= 1'b1;
                    if (words_written != '1)
                        words_written <= words_written + 32'd1;
                    if (last_word) begin
                        busy  <= 1'b0;
                        state <= ST_CMD;
                    end else begin
                        ocd_rw_addr <= ocd_rw_addr + MEM_ADDR_BITS'(1);
                        state       <= ST_DATA;
                    end
                end
                ST_RUN, ST_ERR: state <= state;
                default: begin
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                    error   <= 1'b1;
                    state   <= ST_ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ocd_stream_loader.sv
// Directed bench for ocd_stream_loader across three parameter sets:
// 32-bit LE, 32-bit LE with a 4-bit memory port, and 64-bit BE.
module tb_ocd_stream_loader;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       sv    = 1'b0;
    logic [7:0] sd    = 8'h00;
    int         sel   = 0;

    always #5 clk = ~clk;

    ocd_stream_loader_if #(.XLEN(32), .MEM_ADDR_BITS(16)) bus_a ();
    ocd_stream_loader_if #(.XLEN(32), .MEM_ADDR_BITS(4))  bus_b ();
    ocd_stream_loader_if #(.XLEN(64), .MEM_ADDR_BITS(16)) bus_c ();

    logic        start_a, busy_a, err_a;
    logic [31:0] sa_a, ww_a;
    logic        start_b, busy_b, err_b;
    logic [31:0] sa_b, ww_b;
    logic        start_c, busy_c, err_c;
    logic [31:0] sa_c, ww_c;

    assign bus_a.s_valid = sv && (sel == 0);
    assign bus_b.s_valid = sv && (sel == 1);
    assign bus_c.s_valid = sv && (sel == 2);
    assign bus_a.s_data  = sd;
    assign bus_b.s_data  = sd;
    assign bus_c.s_data  = sd;

    ocd_stream_loader #(.XLEN(32), .MEM_ADDR_BITS(16), .PC_BITWIDTH(32), .PAYLOAD_BIG_ENDIAN(0)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a), .start(start_a), .start_address(sa_a),
        .busy(busy_a), .error(err_a), .words_written(ww_a));
    ocd_stream_loader #(.XLEN(32), .MEM_ADDR_BITS(4), .PC_BITWIDTH(32), .PAYLOAD_BIG_ENDIAN(0)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b), .start(start_b), .start_address(sa_b),
        .busy(busy_b), .error(err_b), .words_written(ww_b));
    ocd_stream_loader #(.XLEN(64), .MEM_ADDR_BITS(16), .PC_BITWIDTH(32), .PAYLOAD_BIG_ENDIAN(1)) dut_c (
        .clk(clk), .reset(reset), .bus(bus_c), .start(start_c), .start_address(sa_c),
        .busy(busy_c), .error(err_c), .words_written(ww_c));

    logic        rdy, we_m;
    logic [15:0] addr_m;
    logic [63:0] data_m;

    assign rdy    = (sel == 0) ? bus_a.s_ready : (sel == 1) ? bus_b.s_ready : bus_c.s_ready;
    assign we_m   = (sel == 0) ? bus_a.ocd_write_enable : (sel == 1) ? bus_b.ocd_write_enable
                                                         : bus_c.ocd_write_enable;
    assign addr_m = (sel == 0) ? bus_a.ocd_rw_addr : (sel == 1) ? {12'h000, bus_b.ocd_rw_addr}
                                                    : bus_c.ocd_rw_addr;
    assign data_m = (sel == 0) ? {32'h0, bus_a.ocd_write_word}
                  : (sel == 1) ? {32'h0, bus_b.ocd_write_word} : bus_c.ocd_write_word;

    typedef struct packed {
        logic [15:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t wq[$];

    always @(negedge clk) begin
        if (we_m === 1'b1) wq.push_back('{addr: addr_m, data: data_m});
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] wr_addr(input int i);
        return (wq.size() > i) ? wq[i].addr : 16'hxxxx;
    endfunction

    function automatic logic [63:0] wr_data(input int i);
        return (wq.size() > i) ? wq[i].data : 64'hxxxx_xxxx_xxxx_xxxx;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [7:0] b);
        int n = 0;
        sv = 1'b1;
        sd = b;
        while (rdy !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("s_ready_for_byte", {63'h0, rdy}, 64'h1);
        if (rdy === 1'b1) @(negedge clk);
        sv = 1'b0;
    endtask

    task automatic send4(input logic [31:0] v);
        send(v[7:0]);
        send(v[15:8]);
        send(v[23:16]);
        send(v[31:24]);
    endtask

    task automatic do_reset();
        sv    = 1'b0;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(1);
        wq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(1);
        check("rst_s_ready", {63'h0, bus_a.s_ready}, 64'h1);
        check("rst_we", {63'h0, bus_a.ocd_write_enable}, 64'h0);
        check("rst_addr", {48'h0, bus_a.ocd_rw_addr}, 64'h0);
        check("rst_word", {32'h0, bus_a.ocd_write_word}, 64'h0);
        check("rst_flags", {60'h0, start_a, busy_a, err_a, 1'b0}, 64'h0);
        check("rst_start_addr", {32'h0, sa_a}, 64'h0);
        check("rst_words", {32'h0, ww_a}, 64'h0);
        reset = 1'b0;
        idle(1);

        // Two full little-endian words
        sel = 0;
        send(8'h01);
        check("t1_busy", {63'h0, busy_a}, 64'h1);
        send4(32'h8000_0000);
        send4(32'd8);
        send(8'h13); send(8'h05); send(8'h00); send(8'h00);
        send(8'h93); send(8'h05); send(8'h10); send(8'h00);
        idle(3);
        check("t1_count", wq.size(), 2);
        check("t1_addr0", {48'h0, wr_addr(0)}, 64'h0000);
        check("t1_data0", wr_data(0), 64'h0000_0513);
        check("t1_addr1", {48'h0, wr_addr(1)}, 64'h0001);
        check("t1_data1", wr_data(1), 64'h0010_0593);
        check("t1_words", {32'h0, ww_a}, 64'd2);
        check("t1_idle", {62'h0, busy_a, bus_a.s_ready}, 64'b01);

        // Partial final word is zero-padded
        wq.delete();
        send(8'h01);
        send4(32'h0000_0010);
        send4(32'd5);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
        idle(3);
        check("t2_count", wq.size(), 2);
        check("t2_addr0", {48'h0, wr_addr(0)}, 64'h0004);
        check("t2_data0", wr_data(0), 64'h4433_2211);
        check("t2_addr1", {48'h0, wr_addr(1)}, 64'h0005);
        check("t2_data1", wr_data(1), 64'h0000_0055);
        check("t2_words", {32'h0, ww_a}, 64'd4);

        // Zero-length LOAD returns to command parsing without a write
        wq.delete();
        send(8'h01);
        send4(32'h0000_0100);
        send4(32'd0);
        idle(3);
        check("t3_count", wq.size(), 0);
        check("t3_busy", {63'h0, busy_a}, 64'h0);

        // START releases the CPU and stops accepting bytes
        send(8'h02);
        send4(32'h8000_0000);
        check("t4_start", {63'h0, start_a}, 64'h1);
        check("t4_start_addr", {32'h0, sa_a}, 64'h8000_0000);
        check("t4_s_ready", {63'h0, bus_a.s_ready}, 64'h0);
        idle(3);
        check("t4_held", {61'h0, start_a, bus_a.s_ready, busy_a}, 64'b100);

        // Illegal command
        do_reset();
        send(8'h07);
        send4(32'h0000_0000);
        check("t5_error", {63'h0, err_a}, 64'h1);
        check("t5_s_ready", {63'h0, bus_a.s_ready}, 64'h0);
        check("t5_busy", {63'h0, busy_a}, 64'h0);

        // Misaligned LOAD address
        do_reset();
        send(8'h01);
        send4(32'h0000_0002);
        idle(4);
        check("t6_error", {63'h0, err_a}, 64'h1);
        check("t6_s_ready", {63'h0, bus_a.s_ready}, 64'h0);
        check("t6_no_write", wq.size(), 0);

        // Word address wraps on a 4-bit memory port
        do_reset();
        sel = 1;
        send(8'h01);
        send4(32'h0000_003C);
        send4(32'd8);
        for (int i = 1; i <= 8; i++) send(8'(i));
        idle(3);
        check("t7_count", wq.size(), 2);
        check("t7_addr0", {48'h0, wr_addr(0)}, 64'h000F);
        check("t7_data0", wr_data(0), 64'h0403_0201);
        check("t7_addr1", {48'h0, wr_addr(1)}, 64'h0000);
        check("t7_data1", wr_data(1), 64'h0807_0605);
        check("t7_words", {32'h0, ww_b}, 64'd2);

        // 64-bit big-endian payload
        do_reset();
        sel = 2;
        send(8'h01);
        send4(32'h0000_0000);
        send4(32'd8);
        for (int i = 1; i <= 8; i++) send(8'(i));
        idle(3);
        check("t8_count", wq.size(), 1);
        check("t8_addr0", {48'h0, wr_addr(0)}, 64'h0000);
        check("t8_data0", wr_data(0), 64'h0102_0304_0506_0708);
        check("t8_words", {32'h0, ww_c}, 64'd1);

        // Reset in the middle of a payload abandons the record
        wq.delete();
        send(8'h01);
        send4(32'h0000_0008);
        send4(32'd8);
        send(8'h01); send(8'h02); send(8'h03);
        check("t9_busy_before", {63'h0, busy_c}, 64'h1);
        reset = 1'b1;
        #1;
        check("t9_rst_busy", {63'h0, busy_c}, 64'h0);
        check("t9_rst_s_ready", {63'h0, bus_c.s_ready}, 64'h1);
        idle(2);
        reset = 1'b0;
        idle(3);
        check("t9_no_write", wq.size(), 0);
        check("t9_words", {32'h0, ww_c}, 64'd0);
        send(8'h02);
        send4(32'h0000_1234);
        check("t9_cmd_after_rst", {63'h0, start_c}, 64'h1);
        check("t9_start_addr", {32'h0, sa_c}, 64'h0000_1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
